// File: rtl/vi_mem_arbiter.sv
// Memory port arbiter for vi_core: shares one memory port between the instruction-fetch
// and data-cache paths, one transaction at a time, and re-issues reads that time out.
module vi_mem_arbiter #(
  parameter int ADDR_W  = 20,
  parameter int LINE_W  = 128,
  parameter int DATA_W  = 32,
  parameter int DC_PRIO = 0,
  parameter int TIMEOUT = 16
) (
  input  logic              clk_i,
  input  logic              rsn_i,
  input  logic              ic_req_i,
  input  logic [ADDR_W-1:0] ic_addr_i,
  output logic              ic_ack_o,
  output logic [LINE_W-1:0] ic_data_o,
  input  logic              dc_req_i,
  input  logic              dc_we_i,
  input  logic              dc_byte_i,
  input  logic [ADDR_W-1:0] dc_addr_i,
  input  logic [DATA_W-1:0] dc_wdata_i,
  output logic              dc_ack_o,
  output logic [LINE_W-1:0] dc_data_o,
  output logic              mem_read_o,
  output logic [ADDR_W-1:0] mem_read_addr_o,
  input  logic              mem_data_ready_i,
  input  logic [LINE_W-1:0] mem_data_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  output logic              mem_write_enable_o,
  output logic              mem_write_byte_o,
  output logic [ADDR_W-1:0] mem_write_addr_o,
  output logic [DATA_W-1:0] mem_write_data_o,
  output logic              mem_retry_o
);

  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, RD_WAIT, RESP} state_t;

  state_t              state_q, state_d;
  logic                last_dc_q, last_dc_d;
  logic                own_dc_q, own_dc_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                ic_ack_q, ic_ack_d, dc_ack_q, dc_ack_d;
  logic [LINE_W-1:0]   ic_data_q, ic_data_d, dc_data_q, dc_data_d;
  logic                mem_read_q, mem_read_d;
  logic [ADDR_W-1:0]   mem_read_addr_q, mem_read_addr_d;
  logic                mem_we_q, mem_we_d, mem_wbyte_q, mem_wbyte_d;
  logic [ADDR_W-1:0]   mem_waddr_q, mem_waddr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic                mem_retry_q, mem_retry_d;
  logic                gnt_any, gnt_dc, gnt_wr, rd_hit;

  // Tie goes to whoever was not granted last, unless dc has fixed priority.
  always_comb begin
    gnt_any = ic_req_i | dc_req_i;
    gnt_dc  = dc_req_i && (!ic_req_i || (DC_PRIO != 0) || !last_dc_q);
    gnt_wr  = gnt_dc && dc_we_i;
    rd_hit  = mem_data_ready_i && (mem_addr_i == addr_q);
  end

  always_ff @(posedge clk_i or negedge rsn_i) begin
    if (!rsn_i) begin
      state_q         <= IDLE;
      last_dc_q       <= 1'b0;
      own_dc_q        <= 1'b0;
      addr_q          <= '0;
      cnt_q           <= '0;
      ic_ack_q        <= 1'b0;
      dc_ack_q        <= 1'b0;
      ic_data_q       <= '0;
      dc_data_q       <= '0;
      mem_read_q      <= 1'b0;
      mem_read_addr_q <= '0;
      mem_we_q        <= 1'b0;
      mem_wbyte_q     <= 1'b0;
      mem_waddr_q     <= '0;
      mem_wdata_q     <= '0;
      mem_retry_q     <= 1'b0;
    end else begin
      state_q         <= state_d;
      last_dc_q       <= last_dc_d;
      own_dc_q        <= own_dc_d;
      addr_q          <= addr_d;
      cnt_q           <= cnt_d;
      ic_ack_q        <= ic_ack_d;
      dc_ack_q        <= dc_ack_d;
      ic_data_q       <= ic_data_d;
      dc_data_q       <= dc_data_d;
      mem_read_q      <= mem_read_d;
      mem_read_addr_q <= mem_read_addr_d;
      mem_we_q        <= mem_we_d;
      mem_wbyte_q     <= mem_wbyte_d;
      mem_waddr_q     <= mem_waddr_d;
      mem_wdata_q     <= mem_wdata_d;
      mem_retry_q     <= mem_retry_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    last_dc_d = last_dc_q;
    own_dc_d  = own_dc_q;
    addr_d    = addr_q;
    case (state_q)
      IDLE: begin
        if (gnt_any) begin
          last_dc_d = gnt_dc;
          own_dc_d  = gnt_dc;
          addr_d    = gnt_dc ? dc_addr_i : ic_addr_i;
          state_d   = gnt_wr ? RESP : RD_WAIT;
        end
      end
      RD_WAIT: if (rd_hit) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Strobes and acks default low; data and address outputs hold.
  always_comb begin
    cnt_d           = cnt_q;
    ic_ack_d        = 1'b0;
    dc_ack_d        = 1'b0;
    ic_data_d       = ic_data_q;
    dc_data_d       = dc_data_q;
    mem_read_d      = 1'b0;
    mem_read_addr_d = mem_read_addr_q;
    mem_we_d        = 1'b0;
    mem_wbyte_d     = mem_wbyte_q;
    mem_waddr_d     = mem_waddr_q;
    mem_wdata_d     = mem_wdata_q;
    mem_retry_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (gnt_wr) begin
          mem_we_d    = 1'b1;
          mem_wbyte_d = dc_byte_i;
          mem_waddr_d = dc_addr_i;
          mem_wdata_d = dc_wdata_i;
          dc_ack_d    = 1'b1;
        end else if (gnt_any) begin
          mem_read_d      = 1'b1;
          mem_read_addr_d = gnt_dc ? dc_addr_i : ic_addr_i;
          cnt_d           = '0;
        end
      end
      RD_WAIT: begin
        if (rd_hit) begin
          if (own_dc_q) begin
            dc_data_d = mem_data_i;
            dc_ack_d  = 1'b1;
          end else begin
            ic_data_d = mem_data_i;
            ic_ack_d  = 1'b1;
          end
        end else if (cnt_q == CNT_TC) begin
          mem_read_d  = 1'b1;
          mem_retry_d = 1'b1;
          cnt_d       = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign ic_ack_o           = ic_ack_q;
  assign dc_ack_o           = dc_ack_q;
  assign ic_data_o          = ic_data_q;
  assign dc_data_o          = dc_data_q;
  assign mem_read_o         = mem_read_q;
  assign mem_read_addr_o    = mem_read_addr_q;
  assign mem_write_enable_o = mem_we_q;
  assign mem_write_byte_o   = mem_wbyte_q;
  assign mem_write_addr_o   = mem_waddr_q;
  assign mem_write_data_o   = mem_wdata_q;
  assign mem_retry_o        = mem_retry_q;

endmodule

// File: tb/tb_vi_mem_arbiter.sv
// Bench for vi_mem_arbiter: behavioural memory, table-driven arbitration rounds with a
// scoreboard, and hand sequences for latency, timeout, mismatch and reset cases.
module tb_vi_mem_arbiter;
  localparam int AW = 20, LW = 128, DW = 32, TO = 16;

  logic clk = 1'b0;
  logic rsn_i = 1'b0;
  always #5 clk = ~clk;

  logic ic_req_i = 0, dc_req_i = 0, dc_we_i = 0, dc_byte_i = 0;
  logic [AW-1:0] ic_addr_i = '0, dc_addr_i = '0;
  logic [DW-1:0] dc_wdata_i = '0;
  logic ic_ack_o, dc_ack_o, mem_read_o, mem_write_enable_o, mem_write_byte_o, mem_retry_o;
  logic [LW-1:0] ic_data_o, dc_data_o;
  logic [AW-1:0] mem_read_addr_o, mem_write_addr_o;
  logic [DW-1:0] mem_write_data_o;
  logic mem_data_ready_i;
  logic [LW-1:0] mem_data_i;
  logic [AW-1:0] mem_addr_i;

  // memory model: responder (resp_en=1) or manual drive
  logic resp_en = 1'b1, man_ready = 1'b0;
  logic [LW-1:0] man_data = '0;
  logic [AW-1:0] man_addr = '0;
  logic rsp_ready = 1'b0;
  logic [LW-1:0] rsp_data = '0;
  logic [AW-1:0] rsp_addr = '0;
  assign mem_data_ready_i = resp_en ? rsp_ready : man_ready;
  assign mem_data_i       = resp_en ? rsp_data  : man_data;
  assign mem_addr_i       = resp_en ? rsp_addr  : man_addr;

  vi_mem_arbiter #(.ADDR_W(AW), .LINE_W(LW), .DATA_W(DW), .DC_PRIO(0), .TIMEOUT(TO)) dut (
    .clk_i(clk), .rsn_i(rsn_i),
    .ic_req_i(ic_req_i), .ic_addr_i(ic_addr_i), .ic_ack_o(ic_ack_o), .ic_data_o(ic_data_o),
    .dc_req_i(dc_req_i), .dc_we_i(dc_we_i), .dc_byte_i(dc_byte_i), .dc_addr_i(dc_addr_i),
    .dc_wdata_i(dc_wdata_i), .dc_ack_o(dc_ack_o), .dc_data_o(dc_data_o),
    .mem_read_o(mem_read_o), .mem_read_addr_o(mem_read_addr_o),
    .mem_data_ready_i(mem_data_ready_i), .mem_data_i(mem_data_i), .mem_addr_i(mem_addr_i),
    .mem_write_enable_o(mem_write_enable_o), .mem_write_byte_o(mem_write_byte_o),
    .mem_write_addr_o(mem_write_addr_o), .mem_write_data_o(mem_write_data_o),
    .mem_retry_o(mem_retry_o));

  // second instance with fixed dc priority and its own always-on responder
  logic ic_req_p = 0, dc_req_p = 0;
  logic [AW-1:0] ic_addr_p = '0, dc_addr_p = '0;
  logic ic_ack_p, dc_ack_p, mem_read_p, mem_we_p, mem_wbyte_p, mem_retry_p;
  logic [LW-1:0] ic_data_p, dc_data_p;
  logic [AW-1:0] mem_read_addr_p, mem_waddr_p;
  logic [DW-1:0] mem_wdata_p;
  logic rdy_p = 1'b0;
  logic [LW-1:0] mdata_p = '0;
  logic [AW-1:0] maddr_p = '0;

  vi_mem_arbiter #(.ADDR_W(AW), .LINE_W(LW), .DATA_W(DW), .DC_PRIO(1), .TIMEOUT(TO)) dut_p (
    .clk_i(clk), .rsn_i(rsn_i),
    .ic_req_i(ic_req_p), .ic_addr_i(ic_addr_p), .ic_ack_o(ic_ack_p), .ic_data_o(ic_data_p),
    .dc_req_i(dc_req_p), .dc_we_i(1'b0), .dc_byte_i(1'b0), .dc_addr_i(dc_addr_p),
    .dc_wdata_i('0), .dc_ack_o(dc_ack_p), .dc_data_o(dc_data_p),
    .mem_read_o(mem_read_p), .mem_read_addr_o(mem_read_addr_p),
    .mem_data_ready_i(rdy_p), .mem_data_i(mdata_p), .mem_addr_i(maddr_p),
    .mem_write_enable_o(mem_we_p), .mem_write_byte_o(mem_wbyte_p),
    .mem_write_addr_o(mem_waddr_p), .mem_write_data_o(mem_wdata_p),
    .mem_retry_o(mem_retry_p));

  logic [LW-1:0] mem [int];

  function automatic logic [LW-1:0] line_of(logic [AW-1:0] a);
    int idx = int'(a >> 4);
    if (mem.exists(idx)) return mem[idx];
    return {4{16'hC0DE, a[19:4]}};
  endfunction

  always @(posedge clk) begin
    rsp_ready <= mem_read_o;
    rsp_addr  <= mem_read_addr_o;
    rsp_data  <= line_of(mem_read_addr_o);
    rdy_p     <= mem_read_p;
    maddr_p   <= mem_read_addr_p;
    mdata_p   <= line_of(mem_read_addr_p);
  end

  always @(posedge clk) begin : wr_commit
    logic [LW-1:0] l;
    int off;
    if (mem_write_enable_o) begin
      l   = line_of(mem_write_addr_o);
      off = int'(mem_write_addr_o[3:0]);
      if (mem_write_byte_o) l[8*off +: 8] = mem_write_data_o[7:0];
      else                  l[8*off +: 32] = mem_write_data_o;
      mem[int'(mem_write_addr_o >> 4)] = l;
    end
  end

  int n_run = 0, n_fail = 0;

  task automatic check(string nm, logic [LW-1:0] act, logic [LW-1:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  typedef struct {
    bit is_dc; bit is_wr; bit byte_sz;
    logic [AW-1:0] addr; logic [DW-1:0] wdata; logic [LW-1:0] data;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    bit ic_en; logic [AW-1:0] ic_addr;
    bit dc_en; bit dc_we; bit dc_byte; logic [AW-1:0] dc_addr; logic [DW-1:0] dc_wdata;
    bit dc_first;
  } vec_t;
  vec_t vecs[6];

  task automatic push_ic(vec_t v);
    exp_t e;
    e.is_dc = 0; e.is_wr = 0; e.byte_sz = 0; e.addr = v.ic_addr; e.wdata = '0;
    e.data = line_of(v.ic_addr);
    sb.push_back(e);
  endtask

  task automatic push_dc(vec_t v);
    exp_t e;
    e.is_dc = 1; e.is_wr = v.dc_we; e.byte_sz = v.dc_byte; e.addr = v.dc_addr;
    e.wdata = v.dc_wdata; e.data = v.dc_we ? '0 : line_of(v.dc_addr);
    sb.push_back(e);
  endtask

  task automatic sb_compare();
    exp_t e;
    if (sb.size() == 0) begin
      n_run++; n_fail++;
      $display("FAIL sb_unexpected_ack: ic_ack=%0b dc_ack=%0b with empty queue", ic_ack_o, dc_ack_o);
      return;
    end
    e = sb.pop_front();
    check("ack_owner_dc", dc_ack_o, e.is_dc);
    if (!e.is_wr) begin
      check("rd_data", e.is_dc ? dc_data_o : ic_data_o, e.data);
    end else begin
      check("wr_strobe", mem_write_enable_o, 1);
      check("wr_byte", mem_write_byte_o, e.byte_sz);
      check("wr_addr", mem_write_addr_o, e.addr);
      check("wr_data", mem_write_data_o, e.wdata);
    end
  endtask

  task automatic run_round(vec_t v);
    bit ic_done, dc_done;
    int n;
    repeat (2) @(negedge clk);
    if (v.ic_en && v.dc_en) begin
      if (v.dc_first) begin push_dc(v); push_ic(v); end
      else            begin push_ic(v); push_dc(v); end
    end else if (v.ic_en) push_ic(v);
    else if (v.dc_en) push_dc(v);
    ic_addr_i = v.ic_addr; ic_req_i = v.ic_en;
    dc_addr_i = v.dc_addr; dc_we_i = v.dc_we; dc_byte_i = v.dc_byte;
    dc_wdata_i = v.dc_wdata; dc_req_i = v.dc_en;
    ic_done = !v.ic_en; dc_done = !v.dc_en; n = 0;
    while (!(ic_done && dc_done) && n < 60) begin
      @(negedge clk); n++;
      if (ic_ack_o || dc_ack_o) begin
        check("single_ack", ic_ack_o & dc_ack_o, 0);
        sb_compare();
      end
      if (ic_ack_o) begin ic_req_i = 0; ic_done = 1; end
      if (dc_ack_o) begin dc_req_i = 0; dc_done = 1; end
    end
    check("round_done", ic_done && dc_done, 1);
    ic_req_i = 0; dc_req_i = 0;
  endtask

  function automatic logic [LW-1:0] all_outs();
    return {ic_ack_o, dc_ack_o, mem_read_o, mem_write_enable_o, mem_write_byte_o, mem_retry_o,
            |ic_data_o, |dc_data_o, |mem_read_addr_o, |mem_write_addr_o, |mem_write_data_o};
  endfunction

  initial begin
    int n, strobes, first;
    vec_t v;
    //               ic  ic_addr     dc we by dc_addr     wdata          dc_first
    vecs[0] = '{1, 20'h01000, 1, 0, 0, 20'h02000, 32'h0,          1};
    vecs[1] = '{0, 20'h00000, 1, 1, 0, 20'h03004, 32'h12345678,   0};
    vecs[2] = '{1, 20'h03000, 1, 0, 0, 20'h04010, 32'h0,          0};
    vecs[3] = '{1, 20'h05000, 1, 0, 0, 20'h06000, 32'h0,          0};
    vecs[4] = '{1, 20'h07000, 0, 0, 0, 20'h00000, 32'h0,          0};
    vecs[5] = '{1, 20'h01000, 1, 1, 1, 20'h08003, 32'h000000AB,   1};

    repeat (2) @(negedge clk);
    check("reset_outs", all_outs(), 0);
    check("reset_outs_prio", {ic_ack_p, dc_ack_p, mem_read_p, mem_we_p, mem_retry_p, |mem_read_addr_p}, 0);
    rsn_i = 1;

    // single read latency
    @(negedge clk); ic_addr_i = 20'h01000; ic_req_i = 1;
    @(negedge clk);
    check("lat_rd_strobe", mem_read_o, 1);
    check("lat_rd_addr", mem_read_addr_o, 20'h01000);
    check("lat_no_ack_k", ic_ack_o, 0);
    @(negedge clk);
    check("lat_strobe_one_cycle", mem_read_o, 0);
    check("lat_no_ack_k1", ic_ack_o, 0);
    @(negedge clk);
    check("lat_ack", ic_ack_o, 1);
    check("lat_data", ic_data_o, line_of(20'h01000));
    ic_req_i = 0;
    @(negedge clk);
    check("lat_ack_pulse", ic_ack_o, 0);
    check("lat_data_hold", ic_data_o, line_of(20'h01000));

    for (int i = 0; i < 6; i++) run_round(vecs[i]);

    // byte write readback
    v = '{1, 20'h08000, 0, 0, 0, 20'h0, 32'h0, 0};
    run_round(v);
    check("byte3_readback", ic_data_o[31:24], 8'hAB);

    // timeout and re-issue
    resp_en = 0; man_ready = 0;
    repeat (2) @(negedge clk);
    ic_addr_i = 20'h0A000; ic_req_i = 1;
    @(negedge clk);
    n = 0; strobes = 0;
    while (!mem_retry_o && n < 40) begin
      @(negedge clk); n++;
      if (mem_read_o) strobes++;
    end
    check("to_cycles", n, TO);
    check("to_strobes", strobes, 1);
    check("to_addr", mem_read_addr_o, 20'h0A000);
    @(negedge clk);
    check("to_retry_pulse", {mem_retry_o, mem_read_o}, 0);
    man_ready = 1; man_addr = 20'h0A000; man_data = line_of(20'h0A000);
    @(negedge clk);
    check("to_ack", ic_ack_o, 1);
    check("to_data", ic_data_o, line_of(20'h0A000));
    man_ready = 0; ic_req_i = 0;
    @(negedge clk);

    // mismatched response address is ignored
    repeat (2) @(negedge clk);
    ic_addr_i = 20'h00020; ic_req_i = 1;
    @(negedge clk);
    man_ready = 1; man_addr = 20'h00010; man_data = {4{32'hDEADBEEF}};
    @(negedge clk);
    check("mm_no_ack", ic_ack_o, 0);
    man_ready = 0;
    @(negedge clk);
    check("mm_no_ack2", ic_ack_o, 0);
    man_ready = 1; man_addr = 20'h00020; man_data = line_of(20'h00020);
    @(negedge clk);
    check("mm_ack", ic_ack_o, 1);
    check("mm_data", ic_data_o, line_of(20'h00020));
    man_ready = 0; ic_req_i = 0;
    @(negedge clk);

    // reset in RD_WAIT, then a stale response
    repeat (2) @(negedge clk);
    ic_addr_i = 20'h0B000; ic_req_i = 1;
    @(negedge clk);
    @(negedge clk);
    rsn_i = 0; ic_req_i = 0;
    #1;
    check("rst_mid_outs", all_outs(), 0);
    @(negedge clk); rsn_i = 1;
    @(negedge clk);
    man_ready = 1; man_addr = 20'h0B000; man_data = line_of(20'h0B000);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("stale_no_ack", {ic_ack_o, dc_ack_o}, 0);
    end
    man_ready = 0; resp_en = 1;
    v = '{1, 20'h0C000, 0, 0, 0, 20'h0, 32'h0, 0};
    run_round(v);

    // fixed dc priority: dc first on every tie
    for (int r = 0; r < 3; r++) begin
      repeat (2) @(negedge clk);
      ic_addr_p = 20'h01000 + AW'(r * 32'h100);
      dc_addr_p = 20'h02000 + AW'(r * 32'h100);
      ic_req_p = 1; dc_req_p = 1; first = -1; n = 0;
      while ((ic_req_p || dc_req_p) && n < 40) begin
        @(negedge clk); n++;
        if (dc_ack_p) begin
          if (first < 0) first = 1;
          check("prio_dc_data", dc_data_p, line_of(dc_addr_p));
          dc_req_p = 0;
        end
        if (ic_ack_p) begin
          if (first < 0) first = 0;
          ic_req_p = 0;
        end
      end
      check("prio_dc_first", first, 1);
      ic_req_p = 0; dc_req_p = 0;
    end

    check("sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
